ee_wr_req_ctrl: RTL

- EEPROM write-request controller, on the `timer_clk` domain.
- Sits directly upstream of the EEPROM write-timing stage:
  - Consumes decoded serial-interface commands (WREN/WRDI/page-write frame).
  - Loads the page buffer.
  - Raises `ee_wbusy_s` to start the HV program sequence.
  - Holds it until the timing stage returns `ee_wdone`, or until a watchdog timeout expires.
- Also maintains the WEL, WIP and timeout status bits.

---
 rtl/ee_wr_req_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ee_wr_req_ctrl.sv
// EEPROM write-request controller (timer_clk domain).
// Accepts decoded WREN/WRDI/page-write commands, loads the page buffer,
// and requests an HV program cycle from the write-timing stage via ee_wbusy_s
// until ee_wdone returns or a watchdog timeout expires.
// Optional feature macro: EE_WR_CNT_EN enables the completed-write counter.
module ee_wr_req_ctrl #(
  parameter int unsigned PAGE_BYTES = 16,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned TMO_CYC    = 4095,
  parameter int unsigned GUARD_CYC  = 3,
  localparam int unsigned PW        = $clog2(PAGE_BYTES)
) (
  input  logic                  timer_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_wren,
  input  logic                  cmd_wrdi,
  input  logic                  cmd_wr_start,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_data,
  input  logic                  cmd_wr_end,
  input  logic                  wp_n,
  input  logic                  ee_wdone,
  output logic                  ee_wbusy_s,
  output logic                  pbuf_we,
  output logic [PW-1:0]         pbuf_waddr,
  output logic [7:0]            pbuf_wdata,
  output logic [PAGE_BYTES-1:0] pbuf_mask,
  output logic [ADDR_W-PW-1:0]  ee_page_addr,
  output logic                  sts_wel,
  output logic                  sts_wip,
  output logic                  sts_tmo,
  output logic [15:0]           wr_cnt
);

  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  localparam int unsigned GW = $clog2(GUARD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_we;
  logic [PW-1:0]         r_waddr;
  logic [7:0]            r_wdata;
  logic [PAGE_BYTES-1:0] r_mask;
  logic [ADDR_W-PW-1:0]  r_page;
  logic [PW-1:0]         r_ptr;
  logic                  r_wel;
  logic                  r_wip;
  logic                  r_tmo;
  logic [TW-1:0]         r_tcnt;
  logic [GW-1:0]         r_gcnt;

  logic [PAGE_BYTES-1:0] w_mask_nxt;
  logic                  w_tmo_hit;

  // Mask including a byte arriving in the same cycle as frame end
  assign w_mask_nxt = byte_vld ? (r_mask | (PAGE_BYTES'(1) << r_ptr)) : r_mask;
  assign w_tmo_hit  = (r_tcnt == TW'(TMO_CYC - 1));

`ifdef EE_WR_CNT_EN
  logic [15:0] r_wr_cnt;

  // Saturating count of writes completed by ee_wdone (timeouts excluded)
  always_ff @(posedge timer_clk) begin
    if (sys_rst) begin
      r_wr_cnt <= 16'h0000;
    end else if ((r_state == S_BUSY) && ee_wdone && (r_wr_cnt != 16'hFFFF)) begin
      r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign wr_cnt = r_wr_cnt;
`else
  assign wr_cnt = 16'h0000;
`endif

  // Main controller FSM with registered outputs
  always_ff @(posedge timer_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_page  <= '0;
      r_ptr   <= '0;
      r_wel   <= 1'b0;
      r_wip   <= 1'b0;
      r_tmo   <= 1'b0;
      r_tcnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_wren) begin
            r_wel <= 1'b1;
            r_tmo <= 1'b0;
          end
          // WRDI assigned last so it wins over a simultaneous WREN
          if (cmd_wrdi) begin
            r_wel <= 1'b0;
          end
          if (cmd_wr_start && r_wel && wp_n) begin
            r_state <= S_LOAD;
            r_page  <= cmd_addr[ADDR_W-1:PW];
            r_ptr   <= cmd_addr[PW-1:0];
            r_mask  <= '0;
          end
        end
        S_LOAD: begin
          if (byte_vld) begin
            r_we    <= 1'b1;
            r_waddr <= r_ptr;
            r_wdata <= byte_data;
            r_ptr   <= r_ptr + PW'(1);
          end
          r_mask <= w_mask_nxt;
          if (cmd_wr_end) begin
            r_state <= (w_mask_nxt != '0) ? S_ARM : S_IDLE;
          end
        end
        S_ARM: begin
          r_busy  <= 1'b1;
          r_wip   <= 1'b1;
          r_tcnt  <= '0;
          r_gcnt  <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          r_tcnt <= r_tcnt + TW'(1);
          if (ee_wdone || w_tmo_hit) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_wel   <= 1'b0;
            r_mask  <= '0;
            // Completion takes priority over a coincident timeout
            if (!ee_wdone) begin
              r_tmo <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Guard lets the timing stage's busy synchroniser see the drop
          if (r_gcnt == GW'(GUARD_CYC - 1)) begin
            r_state <= S_IDLE;
            r_wip   <= 1'b0;
          end else begin
            r_gcnt <= r_gcnt + GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ee_wbusy_s   = r_busy;
  assign pbuf_we      = r_we;
  assign pbuf_waddr   = r_waddr;
  assign pbuf_wdata   = r_wdata;
  assign pbuf_mask    = r_mask;
  assign ee_page_addr = r_page;
  assign sts_wel      = r_wel;
  assign sts_wip      = r_wip;
  assign sts_tmo      = r_tmo;

endmodule
